// File: rtl/rv64_div_pkg.sv
// ---------------------------------------------------------------------------
// rv64_div_pkg
// Shared definitions for the RV64M iterative divider:
//   - XLEN datapath width and the iteration count used by the 32-bit W ops
//   - the eight {opcode[6:0], funct3} encodings the divider recognises
//   - the controller state enum
//   - sext32 helper used for every W-op result
// Optional feature macro used by the divider: DIV_FLUSH_EN
// ---------------------------------------------------------------------------
package rv64_div_pkg;

    localparam int XLEN   = 64;
    localparam int W_ITER = 32;

    localparam logic [9:0] OP_DIV   = 10'b0110011_100;
    localparam logic [9:0] OP_DIVU  = 10'b0110011_101;
    localparam logic [9:0] OP_REM   = 10'b0110011_110;
    localparam logic [9:0] OP_REMU  = 10'b0110011_111;
    localparam logic [9:0] OP_DIVW  = 10'b0111011_100;
    localparam logic [9:0] OP_DIVUW = 10'b0111011_101;
    localparam logic [9:0] OP_REMW  = 10'b0111011_110;
    localparam logic [9:0] OP_REMUW = 10'b0111011_111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// ---------------------------------------------------------------------------
// div_restore_step
// One combinational radix-2 restoring division step on unsigned magnitudes.
// Ports:
//   rem      current partial remainder (always < divisor)
//   quo      dividend bits still to be consumed (MSB first), quotient bits
//            accumulate from the LSB end
//   divisor  divisor magnitude
//   rem_next partial remainder after this step
//   quo_next quotient/dividend register after this step
// ---------------------------------------------------------------------------
module div_restore_step
    import rv64_div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // The shifted remainder can need XLEN+1 bits because rem may be as large
    // as divisor-1 with divisor close to 2^XLEN.
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] diff;

    assign shifted = {rem, quo[XLEN-1]};
    assign fits    = shifted >= {1'b0, divisor};
    // When fits is set the true difference is below divisor, so the low
    // XLEN bits of a modulo-2^XLEN subtraction are exact.
    assign diff    = shifted[XLEN-1:0] - divisor;

    assign rem_next = fits ? diff : shifted[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/rv64_divider.sv
// ---------------------------------------------------------------------------
// rv64_divider
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Operands and opcode are captured on accept; the issuing stage may change
// its inputs while the divider works.
//
// Handshake: div_ready is a request level sampled only in IDLE; an accepted
// request raises busy_o from the next cycle through the DONE cycle, and
// div_finish pulses for exactly the DONE cycle with result_val valid.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   div_ready   request (sampled in IDLE only)
//   inst_op_f3  {opcode[6:0], funct3}
//   div_op1     dividend (rs1)
//   div_op2     divisor (rs2)
//   div_flush   (DIV_FLUSH_EN only) abandon the current operation
//   result_val  quotient or remainder, held outside DONE
//   div_finish  one-cycle completion pulse
//   busy_o      operation in flight
//   dbg_state   current controller state
//
// Latency accept->finish: 65 cycles (64-bit), 33 (W), 1 (special cases).
// Macro DIV_FLUSH_EN adds the div_flush input.
// ---------------------------------------------------------------------------
module rv64_divider
    import rv64_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            div_ready,
    input  logic [9:0]      inst_op_f3,
    input  logic [XLEN-1:0] div_op1,
    input  logic [XLEN-1:0] div_op2,
`ifdef DIV_FLUSH_EN
    input  logic            div_flush,
`endif
    output logic [XLEN-1:0] result_val,
    output logic            div_finish,
    output logic            busy_o,
    output div_state_t      dbg_state
);

    localparam logic [6:0] CNT_FULL = 7'(XLEN);
    localparam logic [6:0] CNT_W    = 7'(W_ITER);

    div_state_t      state;
    logic [6:0]      cnt;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic            q_neg, r_neg, w_op, rem_sel;
    logic            finish_q;
    logic            flush;

`ifdef DIV_FLUSH_EN
    assign flush      = div_flush;
    assign div_finish = finish_q & ~div_flush;
`else
    assign flush      = 1'b0;
    assign div_finish = finish_q;
`endif

    assign dbg_state = state;

    // ---------------- request decode and operand preparation --------------
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            valid_op, is_w, is_signed, sel_rem;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, spec_raw, spec_res;
    logic            sign1, sign2, div_zero, ovf, special;

    assign opc       = inst_op_f3[9:3];
    assign f3        = inst_op_f3[2:0];
    assign valid_op  = f3[2] && (opc == 7'b0110011 || opc == 7'b0111011);
    assign is_w      = opc == 7'b0111011;
    assign is_signed = ~f3[0];
    assign sel_rem   = f3[1];

    assign a_ext = !is_w     ? div_op1 :
                   is_signed ? sext32(div_op1[31:0]) : {32'b0, div_op1[31:0]};
    assign b_ext = !is_w     ? div_op2 :
                   is_signed ? sext32(div_op2[31:0]) : {32'b0, div_op2[31:0]};

    // W operands are already sign-extended, so bit 63 is the sign either way.
    assign sign1 = is_signed & a_ext[XLEN-1];
    assign sign2 = is_signed & b_ext[XLEN-1];
    assign a_abs = sign1 ? -a_ext : a_ext;
    assign b_abs = sign2 ? -b_ext : b_ext;

    assign min_val  = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign div_zero = b_ext == '0;
    assign ovf      = is_signed && (a_ext == min_val) && (b_ext == '1);
    assign special  = !valid_op || div_zero || ovf;

    always_comb begin
        spec_raw = '0;
        if (!valid_op)
            spec_raw = '0;
        else if (div_zero)
            spec_raw = sel_rem ? a_ext : '1;
        else if (ovf)
            spec_raw = sel_rem ? '0 : a_ext;
        spec_res = (valid_op && is_w) ? sext32(spec_raw[31:0]) : spec_raw;
    end

    // ---------------- iteration datapath and final correction -------------
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix, sel_res, final_res;

    div_restore_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // The result is formed from the last step's outputs so it can be
    // registered on the edge that enters DONE.
    assign q_fix     = q_neg ? -quo_nx : quo_nx;
    assign r_fix     = r_neg ? -rem_nx : rem_nx;
    assign sel_res   = rem_sel ? r_fix : q_fix;
    assign final_res = w_op ? sext32(sel_res[31:0]) : sel_res;

    // ---------------- controller ------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            w_op       <= 1'b0;
            rem_sel    <= 1'b0;
            result_val <= '0;
            finish_q   <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    finish_q <= 1'b0;
                    if (!flush && div_ready) begin
                        w_op    <= is_w;
                        rem_sel <= sel_rem;
                        q_neg   <= sign1 ^ sign2;
                        r_neg   <= sign1;
                        busy_o  <= 1'b1;
                        if (special) begin
                            state      <= DONE;
                            result_val <= spec_res;
                            finish_q   <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= is_w ? CNT_W : CNT_FULL;
                            rem_q <= '0;
                            // W magnitudes fit in 32 bits; park them at the
                            // top so 32 steps consume exactly those bits.
                            quo_q <= is_w ? {a_abs[31:0], 32'b0} : a_abs;
                            dvs_q <= b_abs;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt   <= cnt - 7'd1;
                        if (cnt == 7'd1) begin
                            state      <= DONE;
                            result_val <= final_res;
                            finish_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    finish_q <= 1'b0;
                    busy_o   <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    finish_q <= 1'b0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv64_divider.sv
// ---------------------------------------------------------------------------
// tb_rv64_divider
// Table-driven directed vectors, hand-written multi-cycle sequences
// (operand hold, async reset, flush) and randomized operations checked
// against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_rv64_divider;

    localparam logic [9:0] T_DIV   = 10'b0110011_100;
    localparam logic [9:0] T_DIVU  = 10'b0110011_101;
    localparam logic [9:0] T_REM   = 10'b0110011_110;
    localparam logic [9:0] T_REMU  = 10'b0110011_111;
    localparam logic [9:0] T_DIVW  = 10'b0111011_100;
    localparam logic [9:0] T_DIVUW = 10'b0111011_101;
    localparam logic [9:0] T_REMW  = 10'b0111011_110;
    localparam logic [9:0] T_REMUW = 10'b0111011_111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        div_ready = 1'b0;
    logic [9:0]  inst_op_f3 = '0;
    logic [63:0] div_op1 = '0;
    logic [63:0] div_op2 = '0;
    logic [63:0] result_val;
    logic        div_finish;
    logic        busy_o;
    rv64_div_pkg::div_state_t dbg_state;
`ifdef DIV_FLUSH_EN
    logic        div_flush = 1'b0;
`endif

    int n_total = 0;
    int n_pass  = 0;

    rv64_divider dut (
        .clk        (clk),
        .rst        (rst),
        .div_ready  (div_ready),
        .inst_op_f3 (inst_op_f3),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
`ifdef DIV_FLUSH_EN
        .div_flush  (div_flush),
`endif
        .result_val (result_val),
        .div_finish (div_finish),
        .busy_o     (busy_o),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model -------------------------------------
    function automatic logic [63:0] ref_div(input logic [9:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        longint          sx, sy, sq, sr;
        int              wx, wy, wq, wr;
        int unsigned     ux, uy, uq, ur;
        logic [63:0]     lq, lr;
        bit              want_rem;
        want_rem = op[1];
        case (op)
            T_DIV, T_REM: begin
                sx = a; sy = b;
                if (sy == 0) begin sq = -1; sr = sx; end
                else if (sx == 64'sh8000_0000_0000_0000 && sy == -1) begin sq = sx; sr = 0; end
                else begin sq = sx / sy; sr = sx % sy; end
                return want_rem ? sr : sq;
            end
            T_DIVU, T_REMU: begin
                if (b == 0) begin lq = '1; lr = a; end
                else begin lq = a / b; lr = a % b; end
                return want_rem ? lr : lq;
            end
            T_DIVW, T_REMW: begin
                wx = a[31:0]; wy = b[31:0];
                if (wy == 0) begin wq = -1; wr = wx; end
                else if (wx == 32'sh8000_0000 && wy == -1) begin wq = wx; wr = 0; end
                else begin wq = wx / wy; wr = wx % wy; end
                wq = want_rem ? wr : wq;
                return {{32{wq[31]}}, wq};
            end
            T_DIVUW, T_REMUW: begin
                ux = a[31:0]; uy = b[31:0];
                if (uy == 0) begin uq = 32'hFFFF_FFFF; ur = ux; end
                else begin uq = ux / uy; ur = ux % uy; end
                uq = want_rem ? ur : uq;
                return {{32{uq[31]}}, uq};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [9:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        bit is_w, sgn;
        if (op[9:3] != 7'b0110011 && op[9:3] != 7'b0111011) return 1;
        if (!op[2]) return 1;
        is_w = op[9:3] == 7'b0111011;
        sgn  = !op[0];
        if (is_w) begin
            if (b[31:0] == 0) return 1;
            if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        if (b == 0) return 1;
        if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 65;
    endfunction

    // ---------------- checking helpers ------------------------------------
    task automatic check64(input string name, input logic [63:0] act,
                           input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        else
            n_pass++;
    endtask

    // Counts negedges after an accept edge until div_finish; scramble
    // changes the request inputs every cycle to prove they were latched.
    task automatic wait_finish(input int max_cyc, input bit scramble,
                               output int lat, output logic [63:0] res,
                               output bit busy_bad);
        lat = 0; res = 'x; busy_bad = 0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            if (scramble) begin
                div_ready  = 1'b0;
                inst_op_f3 = 10'($urandom);
                div_op1    = {$urandom, $urandom};
                div_op2    = {$urandom, $urandom};
            end
            if (!busy_o) busy_bad = 1;
            if (div_finish) begin
                lat = cyc;
                res = result_val;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [9:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat);
        int          lat;
        logic [63:0] res;
        bit          busy_bad;
        @(negedge clk);
        inst_op_f3 = op; div_op1 = a; div_op2 = b; div_ready = 1'b1;
        @(posedge clk);
        wait_finish(200, 1'b1, lat, res, busy_bad);
        check64({name, "_result"}, res, exp_res);
        check64({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check64({name, "_busy"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        check64({name, "_pulse_end"}, {62'd0, div_finish, busy_o}, 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [9:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    function automatic logic [63:0] rand_opnd();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = 64'($urandom_range(0, 20));
            1: v = 64'd0;
            2: v = '1;
            3: v = 64'h8000_0000_0000_0000;
            4: v = {{32{1'b1}}, $urandom};
            5: v = -64'($urandom_range(1, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [9:0]  ops[9];
        int          lat, cnt_fin;
        logic [63:0] res;
        bit          busy_bad;

        // ---------------- reset state ----------------
        #1;
        check64("reset_result", result_val, 64'd0);
        check64("reset_finish", 64'(div_finish), 64'd0);
        check64("reset_busy", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // ---------------- directed table ----------------
        vecs.push_back('{"divu_100_7",  T_DIVU,  64'd100, 64'd7, 64'd14, 65});
        vecs.push_back('{"remu_100_7",  T_REMU,  64'd100, 64'd7, 64'd2, 65});
        vecs.push_back('{"div_m100_7",  T_DIV,   -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65});
        vecs.push_back('{"rem_m100_7",  T_REM,   -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65});
        vecs.push_back('{"rem_100_m7",  T_REM,   64'd100, -64'd7, 64'd2, 65});
        vecs.push_back('{"div_ovf",     T_DIV,   64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1});
        vecs.push_back('{"rem_ovf",     T_REM,   64'h8000_0000_0000_0000, '1, 64'd0, 1});
        vecs.push_back('{"divu_5_0",    T_DIVU,  64'd5, 64'd0, '1, 1});
        vecs.push_back('{"rem_m5_0",    T_REM,   -64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1});
        vecs.push_back('{"divw_neg",    T_DIVW,  64'h1234_5678_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 33});
        vecs.push_back('{"divuw",       T_DIVUW, 64'h1234_5678_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33});
        vecs.push_back('{"remuw_x_0",   T_REMUW, 64'h0000_0001_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005, 1});
        vecs.push_back('{"divw_ovf",    T_DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
        vecs.push_back('{"remw_m7_2",   T_REMW,  64'h0000_0000_FFFF_FFF9, 64'd2, '1, 33});
        vecs.push_back('{"divu_big",    T_DIVU,  '1, 64'h8000_0000_0000_0001, 64'd1, 65});
        vecs.push_back('{"bad_opcode",  10'b0110011_000, 64'd100, 64'd7, 64'd0, 1});
        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_res, vecs[i].exp_lat);

        // ---------------- hold request and change operands during BUSY ----
        @(negedge clk);
        inst_op_f3 = T_DIVU; div_op1 = 64'd100; div_op2 = 64'd7; div_ready = 1'b1;
        @(posedge clk);
        #1;
        div_op1 = 64'd1000; div_op2 = 64'd3;
        wait_finish(200, 1'b0, lat, res, busy_bad);
        check64("hold_first_result", res, 64'd14);
        check64("hold_first_latency", 64'(lat), 64'd65);
        @(negedge clk);
        check64("hold_idle_gap", {62'd0, div_finish, busy_o}, 64'd0);
        @(negedge clk);
        check64("hold_second_accept", 64'(busy_o), 64'd1);
        div_ready = 1'b0;
        wait_finish(200, 1'b0, lat, res, busy_bad);
        check64("hold_second_result", res, 64'd333);
        check64("hold_second_latency", 64'(lat + 1), 64'd65);
        @(negedge clk);

        // ---------------- asynchronous reset mid-BUSY ----------------
        @(negedge clk);
        inst_op_f3 = T_DIVU; div_op1 = 64'd12345; div_op2 = 64'd11; div_ready = 1'b1;
        @(posedge clk);
        #1 div_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check64("async_rst_busy", 64'(busy_o), 64'd0);
        check64("async_rst_finish", 64'(div_finish), 64'd0);
        check64("async_rst_result", result_val, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cnt_fin = 0;
        repeat (80) begin
            @(negedge clk);
            if (div_finish || busy_o) cnt_fin++;
        end
        check64("async_rst_no_pulse", 64'(cnt_fin), 64'd0);

`ifdef DIV_FLUSH_EN
        // ---------------- flush mid-BUSY and flush over request in IDLE ---
        @(negedge clk);
        inst_op_f3 = T_DIV; div_op1 = 64'd999; div_op2 = 64'd5; div_ready = 1'b1;
        @(posedge clk);
        #1 div_ready = 1'b0;
        repeat (10) @(negedge clk);
        div_flush = 1'b1;
        @(negedge clk);
        div_flush = 1'b0;
        check64("flush_busy_drop", {62'd0, div_finish, busy_o}, 64'd0);
        cnt_fin = 0;
        repeat (80) begin
            @(negedge clk);
            if (div_finish || busy_o) cnt_fin++;
        end
        check64("flush_no_pulse", 64'(cnt_fin), 64'd0);
        @(negedge clk);
        div_flush = 1'b1; div_ready = 1'b1;
        @(negedge clk);
        check64("flush_idle_no_accept", 64'(busy_o), 64'd0);
        div_flush = 1'b0; div_ready = 1'b0;
        @(negedge clk);
`endif

        // ---------------- randomized against the model ----------------
        ops = '{T_DIV, T_DIVU, T_REM, T_REMU, T_DIVW, T_DIVUW, T_REMW, T_REMUW,
                10'b0010011_000};
        for (int i = 0; i < 40; i++) begin
            logic [9:0]  op;
            logic [63:0] a, b;
            op = ops[$urandom_range(0, 8)];
            a  = rand_opnd();
            b  = rand_opnd();
            run_op($sformatf("rand%0d_op%b", i, op), op, a, b,
                   ref_div(op, a, b), ref_lat(op, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
